// File: rtl/mul_stream_ctrl.sv
// Valid/ready streaming wrapper around a fixed-latency, non-stalling 8x8 signed multiplier.
// Optional MUL_STREAM_STATS_EN adds saturating accept/stall counters.
module mul_stream_ctrl #(
    parameter int MUL_LATENCY = 7,
    parameter int FIFO_DEPTH  = 8,
    parameter int TAG_W       = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [7:0]        in_md_i,
    input  logic [7:0]        in_mr_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic [7:0]        mul_md_o,
    output logic [7:0]        mul_mr_o,
    input  logic [15:0]       mul_result_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [15:0]       out_result_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              busy_o
`ifdef MUL_STREAM_STATS_EN
    ,
    output logic [15:0]       stat_ops_o,
    output logic [15:0]       stat_stall_o
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic                                  acc, push, pop, full;
    logic [MUL_LATENCY-1:0]                vld_sr;
    logic [MUL_LATENCY-1:0][TAG_W-1:0]     tag_sr;
    logic [CW-1:0]                         inflight_cnt, fifo_cnt;
    logic [AW-1:0]                         wr_ptr, rd_ptr;
    logic [FIFO_DEPTH-1:0][TAG_W+15:0]     mem;
    logic [CW:0]                           used;

    // Credits count every slot that is already promised: buffered or still inside the multiplier.
    assign used        = {1'b0, fifo_cnt} + {1'b0, inflight_cnt};
    assign in_ready_o  = !rst_i && (used != DEPTH_C);
    assign acc         = in_valid_i && in_ready_o;
    assign push        = vld_sr[MUL_LATENCY-1];
    assign out_valid_o = (fifo_cnt != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign full        = (fifo_cnt == CW'(FIFO_DEPTH));
    assign busy_o      = (inflight_cnt != '0) || (fifo_cnt != '0);

    assign mul_md_o = acc ? in_md_i : 8'h00;
    assign mul_mr_o = acc ? in_mr_i : 8'h00;

    assign out_result_o = mem[rd_ptr][TAG_W+15:TAG_W];
    assign out_tag_o    = mem[rd_ptr][TAG_W-1:0];

    always_ff @(posedge clk_i) begin
        tag_sr[0] <= in_tag_i;
        for (int i = 1; i < MUL_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
        if (rst_i) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= acc;
            for (int i = 1; i < MUL_LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_cnt <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
        end else begin
            if (acc && !push)      inflight_cnt <= inflight_cnt + 1'b1;
            else if (!acc && push) inflight_cnt <= inflight_cnt - 1'b1;
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {mul_result_i, tag_sr[MUL_LATENCY-1]};
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (!(push && full && !pop)) else $error("result FIFO overflow");
    end
`endif

`ifdef MUL_STREAM_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_ops_o   <= '0;
            stat_stall_o <= '0;
        end else begin
            if (acc && stat_ops_o != 16'hFFFF) stat_ops_o <= stat_ops_o + 1'b1;
            if (in_valid_i && !in_ready_o && stat_stall_o != 16'hFFFF)
                stat_stall_o <= stat_stall_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_stream_ctrl.sv
// Directed + random bench for mul_stream_ctrl with a behavioural 7-stage multiplier
// and an acceptance-order scoreboard.
module tb_mul_stream_ctrl;
    localparam int LAT = 7;
    localparam int TW  = 4;

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    logic in_valid_i = 1'b0, out_ready_i = 1'b1;
    logic [7:0] in_md_i = '0, in_mr_i = '0;
    logic [TW-1:0] in_tag_i = '0;
    logic in_ready_o, out_valid_o, busy_o;
    logic [7:0] mul_md_o, mul_mr_o;
    logic [15:0] mul_result_i, out_result_o;
    logic [TW-1:0] out_tag_o;
`ifdef MUL_STREAM_STATS_EN
    logic [15:0] stat_ops_o, stat_stall_o;
`endif

    int n_cmp = 0, n_err = 0, n_acc = 0;
    logic [15+TW:0] sb[$];
    logic [15:0] pipe[LAT];

    always #5 clk = ~clk;

    mul_stream_ctrl #(.MUL_LATENCY(LAT), .FIFO_DEPTH(8), .TAG_W(TW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_md_i(in_md_i), .in_mr_i(in_mr_i), .in_tag_i(in_tag_i),
        .mul_md_o(mul_md_o), .mul_mr_o(mul_mr_o), .mul_result_i(mul_result_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_result_o(out_result_o), .out_tag_o(out_tag_o), .busy_o(busy_o)
`ifdef MUL_STREAM_STATS_EN
        , .stat_ops_o(stat_ops_o), .stat_stall_o(stat_stall_o)
`endif
    );

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb_;
        sa  = $signed({{8{a[7]}}, a});
        sb_ = $signed({{8{b[7]}}, b});
        return 16'(sa * sb_);
    endfunction

    // Non-stalling multiplier: product of operands sampled at edge t appears LAT-1 edges later.
    always @(posedge clk) begin
        for (int i = LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
        pipe[0] <= smul(mul_md_o, mul_mr_o);
    end
    assign mul_result_i = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_i) sb.delete();
        else begin
            if (in_valid_i && in_ready_o) begin
                sb.push_back({smul(in_md_i, in_mr_i), in_tag_i});
                n_acc++;
            end
            if (out_valid_o && out_ready_i) begin
                if (sb.size() == 0) chk("sb_unexpected", {12'h0, out_tag_o, out_result_o}, 32'hDEAD);
                else chk("sb_result", {12'h0, out_result_o, out_tag_o}, {12'h0, sb.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
        #1 chk("rst_ready", in_ready_o, 0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("rst_oval", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ready_after", in_ready_o, 1);
    endtask

    logic [7:0]  cmd[4] = '{8'hFD, 8'h80, 8'h7F, 8'hFF};
    logic [7:0]  cmr[4] = '{8'h05, 8'h80, 8'h80, 8'hFF};
    logic [15:0] cex[4] = '{16'hFFF1, 16'h4000, 16'hC080, 16'h0001};

    initial begin
        int c;
        @(posedge clk); #1;
        do_reset();

        // single op accepted in cycle 0
        in_valid_i = 1; in_md_i = 8'h03; in_mr_i = 8'h05; in_tag_i = 4'd1;
        #1 chk("single_ready", in_ready_o, 1);
        for (c = 1; c <= 9; c++) begin
            tick();
            in_valid_i = 0;
            chk($sformatf("single_oval_c%0d", c), out_valid_o, (c == 8));
            chk($sformatf("single_busy_c%0d", c), busy_o, (c <= 8));
            if (c == 8) begin
                chk("single_result", out_result_o, 16'h000F);
                chk("single_tag", out_tag_o, 1);
            end
        end

        // signed corners, back-to-back
        do_reset();
        for (int i = 0; i < 4; i++) begin
            in_valid_i = 1; in_md_i = cmd[i]; in_mr_i = cmr[i]; in_tag_i = TW'(i + 2);
            tick();
        end
        in_valid_i = 0;
        for (c = 4; c <= 12; c++) begin
            chk($sformatf("corner_oval_c%0d", c), out_valid_o, (c >= 8 && c <= 11));
            if (c >= 8 && c <= 11) chk($sformatf("corner_res_c%0d", c), out_result_o, cex[c-8]);
            tick();
        end

        // backpressure: exactly 8 credits, then drain
        do_reset();
        out_ready_i = 0; in_valid_i = 1;
        for (c = 0; c < 20; c++) begin
            in_md_i = 8'(c * 7 + 1); in_mr_i = 8'(8'd250 - c); in_tag_i = TW'(c);
            #1 chk($sformatf("bp_ready_c%0d", c), in_ready_o, (c < 8));
            tick();
        end
        in_valid_i = 0; out_ready_i = 1;
`ifdef MUL_STREAM_STATS_EN
        chk("stat_ops", stat_ops_o, 8);
        chk("stat_stall", stat_stall_o, 12);
`endif
        chk("bp_full_oval", out_valid_o, 1);
        chk("bp_ready_c20", in_ready_o, 0);
        tick();
        chk("bp_ready_c21", in_ready_o, 1);
        for (int i = 0; i < 7; i++) tick();
        chk("bp_drained_oval", out_valid_o, 0);
        chk("bp_drained_busy", busy_o, 0);
        chk("bp_sb_empty", sb.size(), 0);

        // reset mid-operation
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1; in_md_i = 8'(i + 9); in_mr_i = 8'h11; in_tag_i = TW'(i);
            tick();
        end
        in_valid_i = 0;
        tick();
        rst_i = 1;
        #1 chk("mid_rst_ready", in_ready_o, 0);
        tick();
        rst_i = 0;
        chk("mid_rst_oval", out_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("mid_rst_quiet_%0d", i), out_valid_o, 0);
        end
        in_valid_i = 1; in_md_i = 8'h02; in_mr_i = 8'h02; in_tag_i = 4'd7;
        for (int i = 1; i <= 8; i++) begin
            tick();
            in_valid_i = 0;
            chk($sformatf("post_rst_oval_%0d", i), out_valid_o, (i == 8));
        end
        chk("post_rst_result", out_result_o, 16'h0004);
        chk("post_rst_tag", out_tag_o, 7);
        tick();

        // random stream
        do_reset();
        n_acc = 0;
        c = 0;
        while (n_acc < 1000 && c < 20000) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_md_i     = 8'($urandom);
            in_mr_i     = 8'($urandom);
            in_tag_i    = TW'($urandom);
            out_ready_i = ($urandom_range(0, 3) != 0);
            tick();
            c++;
        end
        in_valid_i = 0; out_ready_i = 1;
        chk("rand_accepts", n_acc, 1000);
        c = 0;
        while ((busy_o || sb.size() != 0) && c < 200) begin
            tick();
            c++;
        end
        chk("rand_drain_done", (c < 200), 1);
        chk("rand_sb_empty", sb.size(), 0);
        chk("rand_busy", busy_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mul_stream_ctrl.md
Name: mul_stream_ctrl

Overview:
Streaming front/back-end for the 8x8 signed radix-4 Booth multiplier pipeline (fixed 7-cycle latency, no stall input). It accepts operand pairs over a valid/ready handshake and drives them into the multiplier. A latency-matched valid/tag shift register tracks each operation through the pipeline, and results are captured into an output FIFO. Credit-based admission guarantees no result is ever dropped, because the multiplier cannot stall.

Parameters:
MUL_LATENCY, 7, cycles from operands driven on mul_md_o/mul_mr_o to product valid on mul_result_i (must be >= 1).
FIFO_DEPTH, 8, output FIFO entries; power of 2, >= 2.
TAG_W, 4, width of the user tag carried alongside each operation.

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset; synchronous, active-high
in_valid_i  in  1  operand pair valid
in_ready_o  out  1  block can accept an operand pair this cycle
in_md_i  in  8  multiplicand, two's complement
in_mr_i  in  8  multiplier, two's complement
in_tag_i  in  TAG_W  user tag
mul_md_o  out  8  to multiplier MD_i
mul_mr_o  out  8  to multiplier MR_i
mul_result_i  in  16  from multiplier result_o
out_valid_o  out  1  FIFO head valid
out_ready_i  in  1  consumer accepts head
out_result_o  out  16  signed product at FIFO head
out_tag_o  out  TAG_W  tag at FIFO head
busy_o  out  1  any operation in flight or any result buffered

Behaviour:
- Accept: acc = in_valid_i & in_ready_o. Pop: pop = out_valid_o & out_ready_i.
- Admission:
  - credits = FIFO_DEPTH - fifo_cnt - inflight_cnt.
  - in_ready_o = !rst_i & (credits != 0). Combinational from registered counters only; no path from in_valid_i or out_ready_i.
- Multiplier drive:
  - mul_md_o = acc ? in_md_i : 0; mul_mr_o = acc ? in_mr_i : 0. Combinational; the multiplier samples on the next edge.
  - Idle cycles therefore inject 0x0 operations, which are ignored.
- Tracking:
  - vld_sr[MUL_LATENCY-1:0] and tag_sr shift every cycle; vld_sr[0] <= acc, tag_sr[0] <= in_tag_i.
  - Operation accepted in cycle t has vld_sr[MUL_LATENCY-1] = 1 in cycle t+MUL_LATENCY, which is the cycle its product is on mul_result_i.
- Capture: push = vld_sr[MUL_LATENCY-1]. On push, write {mul_result_i, tag_sr[MUL_LATENCY-1]} to the FIFO tail.
- Counters:
  - inflight_cnt: +1 on acc, -1 on push; unchanged when both occur.
  - fifo_cnt: +1 on push, -1 on pop; unchanged when both occur.
  - Width clog2(FIFO_DEPTH)+1.
- FIFO:
  - First-word-fall-through; out_valid_o = (fifo_cnt != 0); out_result_o/out_tag_o read from head.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle are both legal, including when full or empty with push.
  - Push to a full FIFO is impossible by construction (credits); flag it with a simulation assertion.
- End-to-end latency: accept in cycle t gives out_valid_o in cycle t+MUL_LATENCY+1 when the FIFO was empty.
- Ordering: results leave in strict acceptance order.
- Throughput: one op per cycle sustained when out_ready_i = 1 and FIFO_DEPTH >= MUL_LATENCY+1. Otherwise throughput is limited to FIFO_DEPTH ops per MUL_LATENCY+1 cycles.
- Credit release: a pop frees a credit visible in the following cycle, not the same cycle.
- busy_o = (inflight_cnt != 0) | (fifo_cnt != 0).
- Reset:
  - On the edge with rst_i = 1: vld_sr, pointers and both counters are cleared. After that edge out_valid_o = 0 and busy_o = 0.
  - in_ready_o is held 0 while rst_i = 1.
  - Reset mid-operation discards all in-flight and buffered results. Stale products still inside the multiplier are ignored because vld_sr is clear.
  - FIFO storage is not reset.

Optional Feature:
MUL_STREAM_STATS_EN
- Defined: adds outputs stat_ops_o[15:0] and stat_stall_o[15:0].
  - stat_ops_o counts accepts; stat_stall_o counts cycles with in_valid_i & !in_ready_o.
  - Both saturate at 16'hFFFF and are cleared by rst_i.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single op: in_md_i=8'h03, in_mr_i=8'h05, tag 1, accepted cycle 0, out_ready_i=1 -> out_valid_o first high cycle 8, out_result_o=16'h000F, out_tag_o=1; busy_o falls cycle 9.
- Signed corners, back-to-back: (8'hFD,8'h05), (8'h80,8'h80), (8'h7F,8'h80), (8'hFF,8'hFF) -> 16'hFFF1, 16'h4000, 16'hC080, 16'h0001, in order on consecutive cycles 8..11.
- Backpressure: out_ready_i=0, in_valid_i held high -> exactly 8 accepts (cycles 0-7), in_ready_o=0 from cycle 8. FIFO fills to 8 with no loss. Raise out_ready_i -> all 8 drain in order; in_ready_o returns high the cycle after the first pop.
- Random stream: 1000 random operand pairs, random in_valid_i/out_ready_i -> every result equals the signed product, in order, with matching tags; no overflow assertion fires.
- Reset mid-operation: 3 ops accepted, rst_i pulsed in cycle 4 -> no output appears for them; out_valid_o=0, busy_o=0 after reset. A new op (8'h02,8'h02) afterwards returns 16'h0004.
- Stats (MUL_STREAM_STATS_EN): backpressure scenario held 20 cycles -> stat_ops_o=8, stat_stall_o=12.
